// File: rtl/seg_digit_display_if.sv
// Display bus between the result producer and seg_digit_display:
// frame strobe and BCD value in, multiplexed segment drive out.
interface seg_digit_display_if;
  logic        frame_vsync;
  logic [23:0] digit;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        disp_update;

  modport master (output frame_vsync, digit, input seg_sel, seg_led, disp_update);
  modport slave  (input frame_vsync, digit, output seg_sel, seg_led, disp_update);
endinterface

// File: rtl/seg_digit_display.sv
// 6-digit multiplexed common-anode 7-segment driver with a per-frame value stabiliser.
// Optional leading-zero blanking is enabled by defining SEG_ZERO_BLANK_EN.
module seg_digit_display #(
  parameter int SCAN_DIV      = 50000,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_digit_display_if.slave  bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);

  function automatic logic [7:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 8'hC0;
      4'h1:    f_decode = 8'hF9;
      4'h2:    f_decode = 8'hA4;
      4'h3:    f_decode = 8'hB0;
      4'h4:    f_decode = 8'h99;
      4'h5:    f_decode = 8'h92;
      4'h6:    f_decode = 8'h82;
      4'h7:    f_decode = 8'hF8;
      4'h8:    f_decode = 8'h80;
      4'h9:    f_decode = 8'h90;
      4'hF:    f_decode = 8'hFF;
      default: f_decode = 8'hBF;
    endcase
  endfunction

  logic          r_vs_d;
  logic [23:0]   r_cand;
  logic [MW-1:0] r_match_cnt;
  logic [23:0]   r_disp_val;
  logic          r_disp_update;
  logic [DW-1:0] r_div_cnt;
  logic [2:0]    r_scan_idx;
  logic [5:0]    r_seg_sel;
  logic [7:0]    r_seg_led;

  logic          w_sample;
  logic [MW-1:0] w_next_cnt;
  logic          w_commit;
  logic          w_div_last;
  logic [2:0]    w_scan_idx_nxt;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [5:0]    w_sel_nxt;
  logic [7:0]    w_led_nxt;

  // Stabiliser: a run of identical frame samples must reach STABLE_FRAMES before commit
  always_comb begin
    w_sample   = bus.frame_vsync & ~r_vs_d;
    w_next_cnt = MW'(1);
    if (bus.digit == r_cand)
      w_next_cnt = (r_match_cnt >= MATCH_MAX) ? MATCH_MAX : r_match_cnt + MW'(1);
    w_commit = w_sample && (w_next_cnt >= MATCH_MAX) && (bus.digit != r_disp_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d        <= 1'b0;
      r_cand        <= 24'h0;
      r_match_cnt   <= '0;
      r_disp_val    <= 24'hFFFFFF;
      r_disp_update <= 1'b0;
    end else begin
      r_vs_d        <= bus.frame_vsync;
      r_disp_update <= w_commit;
      if (w_sample) begin
        r_cand      <= bus.digit;
        r_match_cnt <= w_next_cnt;
      end
      if (w_commit)
        r_disp_val <= bus.digit;
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_scan_idx <= 3'd0;
    end else begin
      r_div_cnt  <= w_div_last ? '0 : r_div_cnt + DW'(1);
      r_scan_idx <= w_scan_idx_nxt;
    end
  end

  // Scan next-state
  always_comb begin
    w_div_last     = (r_div_cnt == DIV_LAST);
    w_scan_idx_nxt = r_scan_idx;
    if (w_div_last)
      w_scan_idx_nxt = (r_scan_idx == 3'd5) ? 3'd0 : r_scan_idx + 3'd1;
  end

  // Scan output decode; select and segments are registered together
  always_comb begin
    w_nibble  = r_disp_val[{r_scan_idx, 2'b00} +: 4];
    w_sel_nxt = ~(6'b1 << r_scan_idx);
`ifdef SEG_ZERO_BLANK_EN
    w_blank   = (r_scan_idx != 3'd0) && ((r_disp_val >> {r_scan_idx, 2'b00}) == 24'h0);
`else
    w_blank   = 1'b0;
`endif
    w_led_nxt = w_blank ? 8'hFF : f_decode(w_nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_sel <= 6'h3F;
      r_seg_led <= 8'hFF;
    end else begin
      r_seg_sel <= w_sel_nxt;
      r_seg_led <= w_led_nxt;
    end
  end

  assign bus.seg_sel     = r_seg_sel;
  assign bus.seg_led     = r_seg_led;
  assign bus.disp_update = r_disp_update;
endmodule
